// File: rtl/wired_inst_queue_pkg.sv
// Shared types and helpers for the wired instruction queue.
//   fetch_excp_t  : fetch-stage exception flags carried with every entry
//   compact_sel_t : result of slot-to-lane compaction (lane count, slot per lane)
//   compact_sel() : maps a fetch mask and exception flag to a compaction selection
// The queue entry type (iq_entry_t) depends on the PACKED_SIZE parameter, so it
// is declared inside the queue module.
package wired_inst_queue_pkg;

    typedef struct packed {
        logic adef;
        logic tlbr;
        logic pif;
        logic ppi;
    } fetch_excp_t;

    typedef struct packed {
        logic [1:0] n_lanes;  // 0..2 entries produced by this packet
        logic       slot0;    // source slot for lane 0
        logic       slot1;    // source slot for lane 1
        logic       raw_pc;   // exception-only packet: lane 0 keeps the packet pc
    } compact_sel_t;

    function automatic compact_sel_t compact_sel(input logic [1:0] mask,
                                                 input logic       has_excp);
        compact_sel_t s;
        s = '0;
        case (mask)
            2'b11: begin
                s.n_lanes = 2'd2;
                s.slot0   = 1'b0;
                s.slot1   = 1'b1;
            end
            2'b01: begin
                s.n_lanes = 2'd1;
                s.slot0   = 1'b0;
            end
            2'b10: begin
                s.n_lanes = 2'd1;
                s.slot0   = 1'b1;
            end
            default: begin
                // An empty packet still has to deliver its exception downstream.
                if (has_excp) begin
                    s.n_lanes = 2'd1;
                    s.raw_pc  = 1'b1;
                end
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/wired_inst_queue_if.sv
// Fetch-side and decode-side bus of the wired instruction queue.
//   flush_i, f_*  : fetch packet in, f_ready_o back-pressure
//   d_*           : two decode lanes out, d_ready_i accepts all presented lanes
// Modports: slave = the queue, master = the surrounding pipeline.
interface wired_inst_queue_if #(
    parameter int PACKED_SIZE = 32
) ();
    import wired_inst_queue_pkg::*;

    logic                        flush_i;
    logic                        f_valid_i;
    logic                        f_ready_o;
    logic [1:0]                  f_mask_i;
    logic [31:0]                 f_pc_i;
    logic [1:0][31:0]            f_inst_i;
    logic [PACKED_SIZE-1:0]      f_pkg_i;
    fetch_excp_t                 f_excp_i;
    logic [1:0]                  d_valid_o;
    logic                        d_ready_i;
    logic [1:0][31:0]            d_pc_o;
    logic [1:0][31:0]            d_inst_o;
    logic [1:0][PACKED_SIZE-1:0] d_pkg_o;
    fetch_excp_t [1:0]           d_excp_o;

    modport slave (
        input  flush_i, f_valid_i, f_mask_i, f_pc_i, f_inst_i, f_pkg_i, f_excp_i, d_ready_i,
        output f_ready_o, d_valid_o, d_pc_o, d_inst_o, d_pkg_o, d_excp_o
    );

    modport master (
        output flush_i, f_valid_i, f_mask_i, f_pc_i, f_inst_i, f_pkg_i, f_excp_i, d_ready_i,
        input  f_ready_o, d_valid_o, d_pc_o, d_inst_o, d_pkg_o, d_excp_o
    );
endinterface

// File: rtl/wired_iq_compact.sv
// Combinational 2-slot to 2-lane compaction with per-lane pc generation.
//   mask/pc/inst/pkg/excp : raw fetch packet
//   n_lanes               : number of entries the packet produces (0..2)
//   lane_*                : compacted lanes, lane 0 oldest; lanes >= n_lanes are don't-care
module wired_iq_compact
    import wired_inst_queue_pkg::*;
#(
    parameter int PACKED_SIZE = 32
) (
    input  logic [1:0]                  mask,
    input  logic [31:0]                 pc,
    input  logic [1:0][31:0]            inst,
    input  logic [PACKED_SIZE-1:0]      pkg,
    input  fetch_excp_t                 excp,
    output logic [1:0]                  n_lanes,
    output logic [1:0][31:0]            lane_pc,
    output logic [1:0][31:0]            lane_inst,
    output logic [1:0][PACKED_SIZE-1:0] lane_pkg,
    output fetch_excp_t [1:0]           lane_excp
);
    compact_sel_t sel;

    always_comb begin
        sel          = compact_sel(mask, |excp);
        n_lanes      = sel.n_lanes;
        lane_pc[0]   = sel.raw_pc ? pc : {pc[31:3], sel.slot0, 2'b00};
        lane_pc[1]   = {pc[31:3], sel.slot1, 2'b00};
        lane_inst[0] = inst[sel.slot0];
        lane_inst[1] = inst[sel.slot1];
        lane_pkg     = {2{pkg}};
        lane_excp    = {2{excp}};
    end
endmodule

// File: rtl/wired_inst_queue.sv
// Decoupling instruction queue between icache fetch-return and decode.
// Compacts 2-slot fetch packets into single-instruction entries and presents
// the two oldest entries per cycle, in order.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wired_inst_queue_if.slave (fetch in, decode lanes out, flush)
// Optional build macro WIRED_IQ_BYPASS_EN: an enqueue into an empty queue is
// presented on the decode lanes in the same cycle and is only stored if the
// decoder does not take it.
module wired_inst_queue
    import wired_inst_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int PACKED_SIZE = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    wired_inst_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]            pc;
        logic [31:0]            inst;
        logic [PACKED_SIZE-1:0] pkg;
        fetch_excp_t            excp;
    } iq_entry_t;

    iq_entry_t mem [DEPTH];

    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_p1, wr_ptr_p1;
    logic [CW-1:0] count;
    logic          f_ready, enq, deq, byp_act;
    logic [1:0]    q_valid, n_wr, n_deq;

    logic [1:0]                  c_n;
    logic [1:0][31:0]            c_pc, c_inst;
    logic [1:0][PACKED_SIZE-1:0] c_pkg;
    fetch_excp_t [1:0]           c_excp;
    iq_entry_t                   ent [2];
    iq_entry_t                   head0, head1;

    wired_iq_compact #(.PACKED_SIZE(PACKED_SIZE)) u_enq_compact (
        .mask(bus.f_mask_i), .pc(bus.f_pc_i), .inst(bus.f_inst_i), .pkg(bus.f_pkg_i),
        .excp(bus.f_excp_i), .n_lanes(c_n), .lane_pc(c_pc), .lane_inst(c_inst),
        .lane_pkg(c_pkg), .lane_excp(c_excp)
    );

    // Two free slots are always reserved, so an enqueue never depends on a
    // same-cycle dequeue and f_ready_o comes purely from the count register.
    assign f_ready       = (count <= CW'(DEPTH - 2));
    assign bus.f_ready_o = f_ready;
    assign enq           = bus.f_valid_i & f_ready & ~bus.flush_i;
    assign q_valid       = (count >= CW'(2)) ? 2'b11 : ((count == CW'(1)) ? 2'b01 : 2'b00);
    assign rd_ptr_p1     = rd_ptr + AW'(1);
    assign wr_ptr_p1     = wr_ptr + AW'(1);
    assign head0         = mem[rd_ptr];
    assign head1         = mem[rd_ptr_p1];

`ifdef WIRED_IQ_BYPASS_EN
    logic [1:0]                  b_n;
    logic [1:0][31:0]            b_pc, b_inst;
    logic [1:0][PACKED_SIZE-1:0] b_pkg;
    fetch_excp_t [1:0]           b_excp;

    wired_iq_compact #(.PACKED_SIZE(PACKED_SIZE)) u_byp_compact (
        .mask(bus.f_mask_i), .pc(bus.f_pc_i), .inst(bus.f_inst_i), .pkg(bus.f_pkg_i),
        .excp(bus.f_excp_i), .n_lanes(b_n), .lane_pc(b_pc), .lane_inst(b_inst),
        .lane_pkg(b_pkg), .lane_excp(b_excp)
    );

    assign byp_act = enq & (count == '0) & (b_n != 2'd0);
`else
    assign byp_act = 1'b0;
`endif

    always_comb begin
        bus.d_valid_o = 2'b00;
        bus.d_pc_o    = {head1.pc, head0.pc};
        bus.d_inst_o  = {head1.inst, head0.inst};
        bus.d_pkg_o   = {head1.pkg, head0.pkg};
        bus.d_excp_o  = {head1.excp, head0.excp};
        if (!bus.flush_i) begin
            bus.d_valid_o = q_valid;
`ifdef WIRED_IQ_BYPASS_EN
            if (byp_act) begin
                bus.d_valid_o = (b_n == 2'd2) ? 2'b11 : 2'b01;
                bus.d_pc_o    = b_pc;
                bus.d_inst_o  = b_inst;
                bus.d_pkg_o   = b_pkg;
                bus.d_excp_o  = b_excp;
            end
`endif
        end
    end

    // Bypassed lanes taken by the decoder never touch storage.
    assign deq   = (|q_valid) & bus.d_ready_i & ~bus.flush_i;
    assign n_deq = !deq ? 2'd0 : (q_valid[1] ? 2'd2 : 2'd1);
    assign n_wr  = (!enq || (byp_act && bus.d_ready_i)) ? 2'd0 : c_n;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ent[i].pc   = c_pc[i];
            ent[i].inst = c_inst[i];
            ent[i].pkg  = c_pkg[i];
            ent[i].excp = c_excp[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_wr);
            rd_ptr <= rd_ptr + AW'(n_deq);
            count  <= count + CW'(n_wr) - CW'(n_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (n_wr != 2'd0) mem[wr_ptr]    <= ent[0];
        if (n_wr == 2'd2) mem[wr_ptr_p1] <= ent[1];
    end
endmodule
